// File: rtl/chunked_addsub.sv
// -----------------------------------------------------------------------------
// chunked_addsub
//   Multi-cycle integer add/subtract unit. The WIDTH-bit operands are added
//   CHUNK bits per clock, with the carry held in a register between slices,
//   so the longest carry chain is CHUNK bits wide rather than WIDTH bits.
//   Subtraction is A + ~B + 1. The unit also does optional signed saturation
//   and produces NZCV-style flags. Both sides use valid/ready handshakes, and
//   only one operation is in flight at a time.
//
// Parameters
//   WIDTH      operand/result width in bits
//   CHUNK      bits added per cycle (WIDTH must be a multiple of CHUNK)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operands/controls valid
//   in_ready   unit can accept (high only in IDLE)
//   src1       operand A
//   src2       operand B
//   op         0 = A+B, 1 = A-B
//   sat        1 = signed saturation on overflow
//   out_valid  result/flags valid
//   out_ready  consumer takes the result
//   out        result
//   carryOut   final carry (for subtract, 1 = no borrow)
//   overflow   signed overflow, taken before saturation
//   zero       out == 0
//   negative   out[WIDTH-1]
// -----------------------------------------------------------------------------
module chunked_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carryOut,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic             sat_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted when subtracting
    logic [WIDTH-1:0] raw_q;    // slices summed so far

    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] raw_next;
    logic [WIDTH-1:0] sat_value;
    logic [WIDTH-1:0] final_out;
    logic             ovf_next;

    // Adds the current slice and builds the full result as it will stand
    // once this slice is written, so that flags on the last slice see every bit.
    // NOTE: each signal written in always_comb gets a value first, before any
    // condition or partial update. This keeps the block free of inferred latches.
    always_comb begin
        slice_sum = {1'b0, a_q[idx*CHUNK +: CHUNK]}
                  + {1'b0, b_q[idx*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry};
        raw_next = raw_q;
        raw_next[idx*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];

        // Signed overflow: the operands have the same sign and the result sign differs.
        ovf_next  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw_next[WIDTH-1] != a_q[WIDTH-1]);
        sat_value = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        final_out = (sat_q && ovf_next) ? sat_value : raw_next;
    end

    // NOTE: all state updates use non-blocking assignments. Every register
    // then takes the value from before the edge, whatever the statement order.
    // The operand registers are also cleared on reset, so nothing undefined
    // can reach the outputs from slices not yet summed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            sat_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            raw_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            carryOut  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= src1;
                        b_q      <= op ? ~src2 : src2;
                        sat_q    <= sat;
                        carry    <= op;          // the +1 of two's-complement subtract
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    raw_q <= raw_next;
                    carry <= slice_sum[CHUNK];
                    if (idx == LAST_IDX) begin
                        out       <= final_out;
                        carryOut  <= slice_sum[CHUNK];
                        overflow  <= ovf_next;
                        zero      <= (final_out == '0);
                        negative  <= final_out[WIDTH-1];
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end

                S_DONE: begin
                    // The result is held until the consumer takes it.
                    // New requests wait until then.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_addsub.sv
// -----------------------------------------------------------------------------
// tb_chunked_addsub
//   Directed bench for chunked_addsub at WIDTH=32, CHUNK=8. A table of
//   hand-computed vectors is followed by hand-written sequences for
//   back-pressure and for reset during an operation.
// -----------------------------------------------------------------------------
module tb_chunked_addsub;

    localparam int WIDTH   = 32;
    localparam int CHUNK   = 8;
    localparam int LATENCY = WIDTH / CHUNK;
    localparam int TIMEOUT = 50;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             op;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carryOut;
    logic             overflow;
    logic             zero;
    logic             negative;

    chunked_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .op        (op),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carryOut  (carryOut),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             op;
        logic             sat;
        logic [WIDTH-1:0] exp_out;
        logic             exp_c;
        logic             exp_v;
        logic             exp_z;
        logic             exp_n;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out after %0d cycles", name, TIMEOUT);
    endtask

    // Presents one operation and returns just after its accept edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic o, input logic s);
        int waited;
        @(negedge clk);
        src1     = a;
        src2     = b;
        op       = o;
        sat      = s;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) timeout_fail("accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = '1;     // scramble the inputs; only the latched copies may be used
        src2     = '1;
        op       = ~o;
        sat      = ~s;
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
    endtask

    // Counts edges from the accept edge until out_valid is seen.
    task automatic wait_done(input string name);
        int edges;
        edges = 0;
        while (!out_valid && edges < TIMEOUT) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) timeout_fail({name, "_done"});
        else            check({name, "_latency"}, 64'(edges), 64'(LATENCY));
    endtask

    task automatic check_result(input vec_t v);
        check({v.name, "_out"}, 64'(out),      64'(v.exp_out));
        check({v.name, "_C"},   64'(carryOut), 64'(v.exp_c));
        check({v.name, "_V"},   64'(overflow), 64'(v.exp_v));
        check({v.name, "_Z"},   64'(zero),     64'(v.exp_z));
        check({v.name, "_N"},   64'(negative), 64'(v.exp_n));
    endtask

    // Assumes out_ready is already high; the next edge drains the result.
    task automatic drain(input string name);
        @(posedge clk);
        #1;
        check({name, "_drain_valid"}, 64'(out_valid), 64'd0);
        check({name, "_drain_ready"}, 64'(in_ready),  64'd1);
    endtask

    vec_t vecs[$];
    vec_t bp_vec;
    vec_t rst_vec;
    logic [WIDTH-1:0] held_out;

    initial begin
        //               name         a             b             op    sat   out           C     V     Z     N
        vecs.push_back('{"add_cross", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_5_7",   32'd5,        32'd7,        1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"sub_7_5",   32'd7,        32'd5,        1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"ovf_nosat", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"ovf_sat",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"neg_sat",   32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"wrap_zero", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"sub_equal", 32'd5,        32'd5,        1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"min_plus",  32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"mixed",     32'h12345678, 32'h0FEDCBA8, 1'b0, 1'b0, 32'h22222220, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sat_noovf", 32'h40000000, 32'h10000000, 1'b0, 1'b1, 32'h50000000, 1'b0, 1'b0, 1'b0, 1'b0});

        bp_vec  = '{"bp",  32'h00001234, 32'h00000111, 1'b0, 1'b0, 32'h00001345, 1'b0, 1'b0, 1'b0, 1'b0};
        rst_vec = '{"rst", 32'd3,        32'd4,        1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        src1      = '0;
        src2      = '0;
        op        = 1'b0;
        sat       = 1'b0;
        #1;
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out",       64'(out),       64'd0);
        check("reset_flags",     64'({carryOut, overflow, zero, negative}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sat);
            wait_done(vecs[i].name);
            check_result(vecs[i]);
            drain(vecs[i].name);
        end

        // Back-pressure: hold the result for 3 cycles and ignore a stray request.
        out_ready = 1'b0;
        start_op(bp_vec.a, bp_vec.b, bp_vec.op, bp_vec.sat);
        wait_done(bp_vec.name);
        check_result(bp_vec);
        held_out = out;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = (c == 1);
            src1     = 32'hDEAD0000;
            src2     = 32'h0000BEEF;
            @(posedge clk);
            #1;
            check("bp_hold_out",   64'(out),       64'(held_out));
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_ready", 64'(in_ready),  64'd0);
        end
        check_result(bp_vec);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("bp");
        // The next operation goes straight in on the following edge.
        start_op(32'h00000010, 32'h00000003, 1'b1, 1'b0);
        wait_done("bp_next");
        check_result('{"bp_next", '0, '0, 1'b0, 1'b0, 32'h0000000D, 1'b1, 1'b0, 1'b0, 1'b0});
        check("bp_keep_out", 64'(out), 64'h0000000D);
        drain("bp_next");

        // Reset in the middle of RUN, with idx at 2, after two slice edges.
        start_op(32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_ready", 64'(in_ready),  64'd1);
        check("rst_mid_out",   64'(out),       64'd0);
        check("rst_mid_flags", 64'({carryOut, overflow, zero, negative}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        start_op(rst_vec.a, rst_vec.b, rst_vec.op, rst_vec.sat);
        wait_done(rst_vec.name);
        check_result(rst_vec);
        drain(rst_vec.name);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
